// File: rtl/shift_issue_stage.sv
// Issue/retire stage for the combinational shift/LUI/hamming unit: buffers decoded
// ops in a small FIFO, presents operands from the head, registers the unit's result.
module shift_issue_stage #(
    parameter int DEPTH = 2,
    parameter int RD_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_imm_sel,
    input  logic [31:0]     in_rs1_val,
    input  logic [31:0]     in_rs2_val,
    input  logic [15:0]     in_imm,
    input  logic [RD_W-1:0] in_rd,
    output logic [31:0]     sh_x,
    output logic [31:0]     sh_y,
    output logic [2:0]      sh_func,
    input  logic [31:0]     sh_c,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        OP_SL  = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_LUI = 3'd3,
        OP_HAM = 3'd4
    } op_e;

    typedef struct packed {
        logic [31:0]     x;
        logic [31:0]     y;
        logic [2:0]      func;
        logic [RD_W-1:0] rd;
        logic            err;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           push_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [4:0]       amt;
    logic             not_empty;
    logic             push;
    logic             pop;

    always_comb begin
        amt        = in_imm_sel ? in_imm[4:0] : in_rs2_val[4:0];
        push_entry = '0;
        push_entry.rd = in_rd;
        case (in_op)
            OP_SL: begin
                push_entry.func = 3'b100;
                push_entry.x    = in_rs1_val;
                push_entry.y    = {27'b0, amt};
            end
            OP_SRL: begin
                push_entry.func = 3'b000;
                push_entry.x    = in_rs1_val;
                push_entry.y    = {27'b0, amt};
            end
            OP_SRA: begin
                push_entry.func = 3'b001;
                push_entry.x    = in_rs1_val;
                push_entry.y    = {27'b0, amt};
            end
            OP_LUI: begin
                push_entry.func = 3'b010;
                push_entry.y    = {16'b0, in_imm};
            end
            OP_HAM: begin
                push_entry.func = 3'b011;
                push_entry.x    = in_rs1_val;
            end
            // Illegal ops flow through as SRL of zero so they retire with result 0.
            default: push_entry.err = 1'b1;
        endcase
    end

    assign not_empty = (count != '0);
    assign in_ready  = (count != FULL);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = not_empty && (!out_valid || out_ready) && !flush;
    assign head      = mem[rd_ptr];

    assign sh_x    = not_empty ? head.x    : '0;
    assign sh_y    = not_empty ? head.y    : '0;
    assign sh_func = not_empty ? head.func : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_err    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_result <= sh_c;
            out_rd     <= head.rd;
            out_err    <= head.err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage with a stand-in combinational shift unit
// and an op-level reference model.
module tb_shift_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_imm_sel;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [15:0] in_imm;
    logic [4:0]  in_rd;
    logic [31:0] sh_x;
    logic [31:0] sh_y;
    logic [2:0]  sh_func;
    logic [31:0] sh_c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_err;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   bp_mode  = 0;

    shift_issue_stage #(.DEPTH(2), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_imm_sel(in_imm_sel), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_rd(in_rd),
        .sh_x(sh_x), .sh_y(sh_y), .sh_func(sh_func), .sh_c(sh_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_err(out_err)
    );

    // Stand-in for the external shift/LUI/hamming unit, keyed on its func code.
    always_comb begin
        case (sh_func)
            3'b100:  sh_c = sh_x << sh_y[4:0];
            3'b000:  sh_c = sh_x >> sh_y[4:0];
            3'b001:  sh_c = $unsigned($signed(sh_x) >>> sh_y[4:0]);
            3'b010:  sh_c = sh_y << 16;
            3'b011:  sh_c = 32'($countones(sh_x));
            default: sh_c = '0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] rs1,
                                       input logic [31:0] rs2, input logic [15:0] imm,
                                       input logic sel, input logic [4:0] rd);
        exp_t e;
        int unsigned amt;
        amt   = sel ? int'(imm % 32) : int'(rs2 % 32);
        e.rd  = rd;
        e.err = 1'b0;
        case (op)
            3'd0: e.res = rs1 << amt;
            3'd1: e.res = rs1 >> amt;
            3'd2: e.res = rs1[31] ? ~((~rs1) >> amt) : (rs1 >> amt);
            3'd3: e.res = {imm, 16'h0000};
            3'd4: e.res = 32'($countones(rs1));
            default: begin
                e.res = '0;
                e.err = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic send(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [15:0] imm, input logic sel, input logic [4:0] rd);
        int guard;
        in_valid   = 1'b1;
        in_op      = op;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
        in_imm     = imm;
        in_imm_sel = sel;
        in_rd      = rd;
        guard      = 0;
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 required 1 within 500 cycles");
        end else begin
            exp_q.push_back(ref_model(op, rs1, rs2, imm, sel, rd));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        while ((exp_q.size() != 0 || out_valid) && cycles < 300) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        if (cycles >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
    endtask

    // Writeback backpressure: 0 = always ready, 1 = stalled, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: retire against the scoreboard and verify outputs hold while stalled.
    initial begin
        logic        stalled;
        logic [31:0] h_res;
        logic [4:0]  h_rd;
        logic        h_err;
        exp_t        e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst || flush) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_result", out_result, h_res);
                    check("hold_rd", 32'(out_rd), 32'(h_rd));
                    check("hold_err", 32'(out_err), 32'(h_err));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got result %h rd %0d required none",
                                 out_result, out_rd);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", out_result, e.res);
                        check("rd", 32'(out_rd), 32'(e.rd));
                        check("err", 32'(out_err), 32'(e.err));
                    end
                    stalled = 1'b0;
                end else if (out_valid) begin
                    stalled = 1'b1;
                    h_res   = out_result;
                    h_rd    = out_rd;
                    h_err   = out_err;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        int cyc;
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_op      = '0;
        in_imm_sel = 1'b0;
        in_rs1_val = '0;
        in_rs2_val = '0;
        in_imm     = '0;
        in_rd      = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sh_x", sh_x, 32'd0);
        check("rst_sh_y", sh_y, 32'd0);
        check("rst_sh_func", 32'(sh_func), 32'd0);

        // SL with register amount, upper amount bits masked; two-cycle latency.
        send(3'd0, 32'h1, 32'h24, 16'h0, 1'b0, 5'd3);
        check("sl_sh_y", sh_y, 32'd4);
        check("sl_sh_func", 32'(sh_func), 32'd4);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("sl_result", out_result, 32'h10);
        wait_drain(cyc);

        // SRA by immediate, then LUI.
        send(3'd2, 32'h8000_0000, 32'h0, 16'h001F, 1'b1, 5'd4);
        send(3'd3, 32'h1234_5678, 32'h0, 16'hABCD, 1'b0, 5'd5);
        check("lui_sh_x", sh_x, 32'd0);
        check("lui_sh_y", sh_y, 32'h0000_ABCD);
        check("lui_sh_func", 32'(sh_func), 32'd2);
        wait_drain(cyc);

        // HAM.
        send(3'd4, 32'hF0F0_0001, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 5'd7);
        check("ham_sh_func", 32'(sh_func), 32'd3);
        check("ham_sh_y", sh_y, 32'd0);
        check("ham_sh_x", sh_x, 32'hF0F0_0001);
        wait_drain(cyc);

        // Backpressure: output register plus full FIFO, then release.
        bp_mode = 1;
        repeat (2) @(negedge clk);
        send(3'd0, 32'h0000_00FF, 32'h8, 16'h0, 1'b0, 5'd10);
        send(3'd1, 32'hFF00_0000, 32'h0, 16'h0004, 1'b1, 5'd11);
        send(3'd4, 32'hFFFF_FFFF, 32'h0, 16'h0, 1'b0, 5'd12);
        check("full_in_ready", 32'(in_ready), 32'd0);
        repeat (5) @(negedge clk);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        bp_mode = 0;
        wait_drain(cyc);
        n_checks++;
        if (cyc > 5) begin
            n_fail++;
            $display("FAIL drain_rate: got %0d cycles required at most 5", cyc);
        end

        // Illegal op followed by a legal one.
        send(3'd6, 32'hDEAD_BEEF, 32'h3, 16'h7777, 1'b0, 5'd20);
        send(3'd1, 32'hDEAD_BEEF, 32'h3, 16'h7777, 1'b0, 5'd21);
        wait_drain(cyc);

        // Flush with two buffered ops and a simultaneous push.
        bp_mode = 1;
        repeat (2) @(negedge clk);
        send(3'd0, 32'h1, 32'h1, 16'h0, 1'b0, 5'd1);
        send(3'd0, 32'h2, 32'h1, 16'h0, 1'b0, 5'd2);
        in_valid   = 1'b1;
        in_op      = 3'd3;
        in_imm     = 16'h5555;
        in_rd      = 5'd9;
        flush      = 1'b1;
        check("flush_pre_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_sh_func", 32'(sh_func), 32'd0);
        bp_mode = 0;
        repeat (6) @(negedge clk);
        send(3'd0, 32'h3, 32'h2, 16'h0, 1'b0, 5'd13);
        wait_drain(cyc);

        // Asynchronous reset in the middle of a stall.
        bp_mode = 1;
        repeat (2) @(negedge clk);
        send(3'd4, 32'h7, 32'h0, 16'h0, 1'b0, 5'd14);
        send(3'd3, 32'h0, 32'h0, 16'h1234, 1'b0, 5'd15);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_result", out_result, 32'd0);
        check("arst_out_rd", 32'(out_rd), 32'd0);
        check("arst_out_err", 32'(out_err), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_sh_x", sh_x, 32'd0);
        check("arst_sh_func", 32'(sh_func), 32'd0);
        bp_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with random backpressure.
        bp_mode = 2;
        for (int i = 0; i < 200; i++) begin
            send(3'($urandom_range(0, 7)), $urandom, $urandom, 16'($urandom),
                 1'($urandom_range(0, 1)), 5'($urandom));
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
        bp_mode = 0;
        wait_drain(cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
